// File: rtl/pipe_skid_register_if.sv
// Valid/ready stream bundle carrying one control and one data payload.
// The producer side uses the master modport; the consumer side uses the slave modport.
interface pipe_skid_register_if #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 32
);
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;

    modport master (output valid, output ctrl, output data, input ready);
    modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_skid_register.sv
// Elastic pipeline-stage register with a 2-entry skid buffer. Upstream ready is a
// decode of the state register only, so no combinational ready path crosses the stage.
module pipe_skid_register #(
    parameter int                CTRL_W      = 8,
    parameter int                DATA_W      = 32,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0,
    parameter logic [DATA_W-1:0] BUBBLE_DATA = DATA_W'(32'h2A2A_2A2A)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    pipe_skid_register_if.slave   in_if,
    pipe_skid_register_if.master  out_if,
    output logic [1:0]            occupancy_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;

    logic in_ready;
    logic out_valid;
    logic in_fire;
    logic out_fire;

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign in_fire   = in_if.valid & in_ready;
    assign out_fire  = out_valid & out_if.ready;

    // NOTE: every next-state variable takes its hold value first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;

        if (flush_i) begin
            // Flush wins over both fires; the skid contents are left as they are.
            state_d     = EMPTY;
            main_ctrl_d = BUBBLE_CTRL;
            main_data_d = BUBBLE_DATA;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_ctrl_d = in_if.ctrl;
                        main_data_d = in_if.data;
                        state_d     = BUSY;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        main_ctrl_d = in_if.ctrl;
                        main_data_d = in_if.data;
                    end else if (in_fire) begin
                        skid_ctrl_d = in_if.ctrl;
                        skid_data_d = in_if.data;
                        state_d     = FULL;
                    end else if (out_fire) begin
                        state_d     = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                        state_d     = BUSY;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // NOTE: payload registers are reset too, because the reset value of Out_Data (zero) is observable.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= EMPTY;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
        end
    end

    assign in_if.ready  = in_ready;
    assign out_if.valid = out_valid;
    assign out_if.ctrl  = out_valid ? main_ctrl_q : BUBBLE_CTRL;
    assign out_if.data  = main_data_q;
    assign occupancy_o  = {state_q == FULL, state_q == BUSY};

endmodule

// File: tb/tb_pipe_skid_register.sv
// Scoreboard bench for pipe_skid_register: directed reset/stream/stall/flush cases,
// then a long constrained-random valid/ready/flush run against a queue model.
module tb_pipe_skid_register;

    localparam int          CTRL_W      = 8;
    localparam int          DATA_W      = 32;
    localparam logic [7:0]  BUBBLE_CTRL = 8'h00;
    localparam logic [31:0] BUBBLE_DATA = 32'h2A2A_2A2A;

    typedef struct {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic [1:0] occ;

    pipe_skid_register_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) up_if ();
    pipe_skid_register_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) dn_if ();

    pipe_skid_register #(
        .CTRL_W      (CTRL_W),
        .DATA_W      (DATA_W),
        .BUBBLE_CTRL (BUBBLE_CTRL),
        .BUBBLE_DATA (BUBBLE_DATA)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (flush),
        .in_if       (up_if.slave),
        .out_if      (dn_if.master),
        .occupancy_o (occ)
    );

    always #5 clk = ~clk;

    int          n_vectors     = 0;
    int          n_miscompares = 0;
    entry_t      sb[$];
    logic [31:0] last_data     = '0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vectors++;
        if (act !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Expected outputs follow from the queue alone: its depth is the occupancy.
    task automatic check_outputs(input string tag);
        int n;
        n = sb.size();
        check({tag, ":occ"},       32'(occ),          32'(n));
        check({tag, ":in_ready"},  32'(up_if.ready),  32'(n != 2));
        check({tag, ":out_valid"}, 32'(dn_if.valid),  32'(n != 0));
        if (n != 0) begin
            check({tag, ":out_ctrl"}, 32'(dn_if.ctrl), 32'(sb[0].ctrl));
            check({tag, ":out_data"}, dn_if.data,      sb[0].data);
        end else begin
            check({tag, ":out_ctrl"}, 32'(dn_if.ctrl), 32'(BUBBLE_CTRL));
            check({tag, ":out_data"}, dn_if.data,      last_data);
        end
    endtask

    // Drive one cycle of stimulus, check mid-cycle, then advance the model at the edge.
    task automatic cycle(input string tag, input logic v, input logic [7:0] c,
                         input logic [31:0] d, input logic ordy, input logic fl);
        int     n;
        entry_t e;
        up_if.valid = v;
        up_if.ctrl  = c;
        up_if.data  = d;
        dn_if.ready = ordy;
        flush       = fl;
        @(negedge clk);
        check_outputs(tag);
        @(posedge clk);
        n = sb.size();
        if (fl) begin
            sb.delete();
            last_data = BUBBLE_DATA;
        end else begin
            if (n != 0 && ordy) begin
                e = sb.pop_front();
                last_data = e.data;
            end
            if (v && n != 2) begin
                e.ctrl = c;
                e.data = d;
                sb.push_back(e);
            end
        end
        #1;
    endtask

    initial begin
        up_if.valid = 1'b0;
        up_if.ctrl  = '0;
        up_if.data  = '0;
        dn_if.ready = 1'b0;

        #12;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 1; i <= 5; i++)
            cycle("stream", 1'b1, 8'h10 + 8'(i), 32'(i), 1'b1, 1'b0);
        cycle("stream_drain", 1'b0, 8'h00, 32'h0, 1'b1, 1'b0);
        cycle("stream_idle",  1'b0, 8'h00, 32'h0, 1'b1, 1'b0);

        cycle("stall_a",    1'b1, 8'h21, 32'hA, 1'b0, 1'b0);
        cycle("stall_b",    1'b1, 8'h22, 32'hB, 1'b0, 1'b0);
        cycle("stall_hold", 1'b1, 8'h23, 32'hF, 1'b0, 1'b0);
        cycle("stall_hold", 1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            cycle("stall_pop", 1'b0, 8'h00, 32'h0, 1'b1, 1'b0);

        cycle("fill_1",     1'b1, 8'h31, 32'hE1, 1'b0, 1'b0);
        cycle("fill_2",     1'b1, 8'h32, 32'hE2, 1'b0, 1'b0);
        cycle("flush_full", 1'b1, 8'h33, 32'hC,  1'b0, 1'b1);
        cycle("post_flush", 1'b0, 8'h00, 32'h0,  1'b1, 1'b0);
        cycle("post_flush", 1'b0, 8'h00, 32'h0,  1'b1, 1'b0);

        cycle("busy_1",     1'b1, 8'h41, 32'h55, 1'b0, 1'b0);
        cycle("flush_busy", 1'b0, 8'h00, 32'h0,  1'b1, 1'b1);
        cycle("push_d",     1'b1, 8'h42, 32'hD,  1'b1, 1'b0);
        cycle("see_d",      1'b0, 8'h00, 32'h0,  1'b0, 1'b0);
        cycle("drain_d",    1'b0, 8'h00, 32'h0,  1'b1, 1'b0);
        cycle("drain_d",    1'b0, 8'h00, 32'h0,  1'b1, 1'b0);

        cycle("pre_rst_1", 1'b1, 8'h51, 32'h77, 1'b0, 1'b0);
        cycle("pre_rst_2", 1'b1, 8'h52, 32'h88, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        last_data = '0;
        check_outputs("async_reset");
        up_if.valid = 1'b0;
        dn_if.ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle("first_after_rst", 1'b1, 8'h61, 32'h99, 1'b1, 1'b0);
        cycle("first_after_rst", 1'b0, 8'h00, 32'h0,  1'b1, 1'b0);

        for (int i = 0; i < 10000; i++)
            cycle("rand",
                  1'($urandom_range(0, 99) < 70),
                  8'($urandom),
                  32'($urandom),
                  1'($urandom_range(0, 99) < 60),
                  1'($urandom_range(0, 99) < 4));
        for (int i = 0; i < 4; i++)
            cycle("rand_drain", 1'b0, 8'h00, 32'h0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
